muldiv_sequencer: RTL and testbench

- Multi-cycle execute-stage unit for RV32M ops (ALU_MUL..ALU_REMU from the ALU decoder's alucontrol_t).
- Latches operands on request, runs a pipelined multiply or a radix-2 restoring divide, and returns a single-cycle result pulse.
- Drives a stall to the hazard unit while an operation is in flight.
- Non-M alucontrol values never touch this block.

---
 rtl/muldiv_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// ----------------
// Multi-cycle execute-stage unit for the RV32M operations. An accepted
// request latches its operands, then either runs a MUL_CYCLES-deep multiply
// pipeline or a radix-2 restoring divider (one quotient bit per cycle). The
// result is presented for exactly one cycle (DONE) and held afterwards.
//
// alucontrol encoding (shared with the ALU decoder): the eight M-extension
// operations occupy 5'b10xxx, with the low three bits selecting
// MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU in that order.
//
// Ports:
//   clk          core clock
//   reset        asynchronous active-high reset
//   start        execute-stage instruction valid with an M-extension op
//   flush        kill in-flight op (branch mispredict / trap)
//   alucontrol   operation select
//   src_a        rs1 / dividend / multiplicand
//   src_b        rs2 / divisor / multiplier
//   busy         unit is not idle
//   stall        hold IF/ID/EX (combinational)
//   result_valid one-cycle result pulse
//   result       M-op result, meaningful with result_valid, held until the next
module muldiv_sequencer #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [4:0]      alucontrol,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            busy,
  output logic            stall,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam logic [4:0] ALU_MUL    = 5'b10000;
  localparam logic [4:0] ALU_MULH   = 5'b10001;
  localparam logic [4:0] ALU_MULHSU = 5'b10010;
  localparam logic [4:0] ALU_MULHU  = 5'b10011;
  localparam logic [4:0] ALU_DIV    = 5'b10100;
  localparam logic [4:0] ALU_DIVU   = 5'b10101;
  localparam logic [4:0] ALU_REM    = 5'b10110;
  localparam logic [4:0] ALU_REMU   = 5'b10111;

  localparam int CNT_MAX = (XLEN > MUL_CYCLES) ? XLEN : MUL_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] x);
    return (~x) + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [XLEN-1:0] f_abs(input logic [XLEN-1:0] x);
    return x[XLEN-1] ? f_neg(x) : x;
  endfunction

  state_t              r_state;
  state_t              w_next;

  logic [2:0]          r_op;
  logic [XLEN-1:0]     r_a;
  logic [XLEN-1:0]     r_b;
  logic [CW-1:0]       r_cnt;
  logic [XLEN-1:0]     r_quo;
  logic [XLEN-1:0]     r_rem;
  logic [XLEN-1:0]     r_divisor;
  logic                r_quot_neg;
  logic                r_rem_neg;
  logic                r_special;
  logic [XLEN-1:0]     r_result;
  logic [2*XLEN-1:0]   r_prod_p [MUL_CYCLES];

  logic                w_is_m;
  logic                w_accept;
  logic                w_div_signed_in;
  logic                w_div_special;
  logic [XLEN-1:0]     w_spec_val;
  logic                w_a_sgn;
  logic                w_b_sgn;
  logic [2*XLEN-1:0]   w_a_ext;
  logic [2*XLEN-1:0]   w_b_ext;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN:0]       w_shift;
  logic                w_ge;
  logic [XLEN-1:0]     w_diff;
  logic [XLEN-1:0]     w_done_val;

  // Operation decode on the incoming request
  always_comb begin
    w_is_m          = 1'b0;
    w_div_signed_in = 1'b0;
    case (alucontrol)
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIVU, ALU_REMU: w_is_m = 1'b1;
      ALU_DIV, ALU_REM: begin
        w_is_m          = 1'b1;
        w_div_signed_in = 1'b1;
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and control outputs
  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    busy         = (r_state != S_IDLE);
    stall        = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && w_is_m && !flush) begin
          w_accept = 1'b1;
          stall    = 1'b1;
          w_next   = alucontrol[2] ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        stall = 1'b1;
        if (r_cnt == CW'(MUL_CYCLES - 1)) w_next = S_DONE;
      end
      S_DIV: begin
        stall = 1'b1;
        // Special cases are resolved on the first divide cycle only.
        if ((r_cnt == '0 && w_div_special) || r_cnt == CW'(XLEN - 1)) w_next = S_DONE;
      end
      S_DONE: begin
        result_valid = !flush;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  // Multiplier operand extension: MULH signs both, MULHSU only src_a.
  assign w_a_sgn = ((r_op == 3'd1) || (r_op == 3'd2)) && r_a[XLEN-1];
  assign w_b_sgn = (r_op == 3'd1) && r_b[XLEN-1];
  assign w_a_ext = {{XLEN{w_a_sgn}}, r_a};
  assign w_b_ext = {{XLEN{w_b_sgn}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Multiply pipeline: stage 0 captures the product, later stages delay it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MUL_CYCLES; i++) r_prod_p[i] <= '0;
    end else begin
      r_prod_p[0] <= w_prod;
      for (int i = 1; i < MUL_CYCLES; i++) r_prod_p[i] <= r_prod_p[i-1];
    end
  end

  // Divider step: shift in the next dividend bit and try a subtraction.
  // Because the partial remainder stays below the divisor, a successful
  // subtraction always fits in XLEN bits.
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, r_divisor});
  assign w_diff  = w_shift[XLEN-1:0] - r_divisor;

  assign w_div_special = (r_b == '0) ||
                         (!r_op[0] && (r_a == MOST_NEG) && (r_b == '1));

  always_comb begin
    w_spec_val = '0;
    if (r_b == '0) w_spec_val = r_op[1] ? r_a : '1;
    else           w_spec_val = r_op[1] ? '0 : r_a;
  end

  // Final value presented in DONE
  always_comb begin
    w_done_val = '0;
    if (!r_op[2]) begin
      w_done_val = (r_op[1:0] == 2'd0) ? r_prod_p[MUL_CYCLES-1][XLEN-1:0]
                                       : r_prod_p[MUL_CYCLES-1][2*XLEN-1:XLEN];
    end else if (r_special) begin
      w_done_val = w_spec_val;
    end else if (r_op[1]) begin
      w_done_val = r_rem_neg ? f_neg(r_rem) : r_rem;
    end else begin
      w_done_val = r_quot_neg ? f_neg(r_quo) : r_quo;
    end
  end

  // Operand latch, iteration counter and divider datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_cnt      <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_divisor  <= '0;
      r_quot_neg <= 1'b0;
      r_rem_neg  <= 1'b0;
      r_special  <= 1'b0;
      r_result   <= '0;
    end else begin
      if (w_accept) begin
        r_op       <= alucontrol[2:0];
        r_a        <= src_a;
        r_b        <= src_b;
        r_cnt      <= '0;
        r_rem      <= '0;
        r_special  <= 1'b0;
        r_quo      <= w_div_signed_in ? f_abs(src_a) : src_a;
        r_divisor  <= w_div_signed_in ? f_abs(src_b) : src_b;
        r_quot_neg <= w_div_signed_in && (src_a[XLEN-1] ^ src_b[XLEN-1]);
        r_rem_neg  <= w_div_signed_in && src_a[XLEN-1];
      end else if (r_state == S_MUL) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == S_DIV) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == '0 && w_div_special) begin
          r_special <= 1'b1;
        end else begin
          r_rem <= w_ge ? w_diff : w_shift[XLEN-1:0];
          r_quo <= {r_quo[XLEN-2:0], w_ge};
        end
      end
      // A flushed DONE keeps the previously delivered result.
      if (r_state == S_DONE && !flush) r_result <= w_done_val;
    end
  end

  assign result = (r_state == S_DONE) ? w_done_val : r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer (XLEN=32, MUL_CYCLES=2).
module tb_muldiv_sequencer;

  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_MUL    = 5'b10000;
  localparam logic [4:0] ALU_MULH   = 5'b10001;
  localparam logic [4:0] ALU_MULHSU = 5'b10010;
  localparam logic [4:0] ALU_MULHU  = 5'b10011;
  localparam logic [4:0] ALU_DIV    = 5'b10100;
  localparam logic [4:0] ALU_DIVU   = 5'b10101;
  localparam logic [4:0] ALU_REM    = 5'b10110;
  localparam logic [4:0] ALU_REMU   = 5'b10111;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [4:0]  alucontrol;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        stall;
  logic        result_valid;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(32), .MUL_CYCLES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .flush        (flush),
    .alucontrol   (alucontrol),
    .src_a        (src_a),
    .src_b        (src_b),
    .busy         (busy),
    .stall        (stall),
    .result_valid (result_valid),
    .result       (result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, follow it to its pulse, and check value, latency,
  // stall length and post-pulse state. Latency counts edges from the edge
  // at which start is first driven.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input bit scramble);
    int lat;
    int stalls;
    bit got;
    @(posedge clk); #1;
    start = 1'b1; alucontrol = op; src_a = a; src_b = b;
    @(negedge clk);
    check({tag, "_stall_req"}, {31'b0, stall}, 32'd1);
    got = 1'b0; stalls = 0; lat = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk); @(negedge clk);
      if (scramble) begin src_a = $urandom; src_b = $urandom; end
      if (result_valid) begin
        got = 1'b1;
        lat = i + 1;
        check({tag, "_result"}, result, exp);
        check({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
      end else if (stall) begin
        stalls++;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat - 1));
    @(posedge clk); @(negedge clk);
    check({tag, "_rv_after"}, {31'b0, result_valid}, 32'd0);
    check({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
    check({tag, "_result_held"}, result, exp);
  endtask

  task automatic count_pulses(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    check(tag, 32'(pulses), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    alucontrol = ALU_ADD; src_a = '0; src_b = '0;
    #12;
    check("rst_busy",   {31'b0, busy}, 32'd0);
    check("rst_stall",  {31'b0, stall}, 32'd0);
    check("rst_rv",     {31'b0, result_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    reset = 1'b0;

    // Reset in the middle of a divide
    @(posedge clk); #1;
    start = 1'b1; alucontrol = ALU_DIVU; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b1; start = 1'b0;
    #1;
    check("rstmid_busy",  {31'b0, busy}, 32'd0);
    check("rstmid_stall", {31'b0, stall}, 32'd0);
    check("rstmid_rv",    {31'b0, result_valid}, 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    count_pulses("rstmid_no_pulse", 40);
    run_op("divu_after_rst", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);

    // Multiplies
    run_op("mulh",   ALU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 3, 1'b0);
    run_op("mulhsu", ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 1'b0);
    run_op("mulhu",  ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3, 1'b0);
    run_op("mul",    ALU_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 3, 1'b1);

    // Normal divides
    run_op("div_neg",  ALU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
    run_op("rem_neg",  ALU_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("divu_big", ALU_DIVU, 32'hFFFF_FFFE, 32'd2, 32'h7FFF_FFFF, 33, 1'b0);

    // Special cases
    run_op("div_by0",  ALU_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 2, 1'b0);
    run_op("remu_by0", ALU_REMU, 32'd5, 32'd0, 32'd5, 2, 1'b0);
    run_op("div_ovf",  ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1'b0);
    run_op("rem_ovf",  ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, 1'b0);

    // Flush partway through a divide
    @(posedge clk); #1;
    start = 1'b1; alucontrol = ALU_DIV; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    repeat (14) @(posedge clk);
    #1;
    flush = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy",  {31'b0, busy}, 32'd0);
    check("flush_stall", {31'b0, stall}, 32'd0);
    count_pulses("flush_no_pulse", 40);
    run_op("mul_after_flush", ALU_MUL, 32'd3, 32'd4, 32'd12, 3, 1'b0);

    // Non-M op is ignored
    @(posedge clk); #1;
    start = 1'b1; alucontrol = ALU_ADD; src_a = 32'd1; src_b = 32'd2;
    @(negedge clk);
    check("add_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    check("add_busy", {31'b0, busy}, 32'd0);
    start = 1'b0;

    // flush wins over start in IDLE
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; alucontrol = ALU_MUL; src_a = 32'd2; src_b = 32'd2;
    @(negedge clk);
    check("flushstart_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    check("flushstart_busy", {31'b0, busy}, 32'd0);
    start = 1'b0; flush = 1'b0;

    // flush while in DONE suppresses the pulse
    @(posedge clk); #1;
    start = 1'b1; alucontrol = ALU_MUL; src_a = 32'd5; src_b = 32'd6;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("done_flush_busy", {31'b0, busy}, 32'd1);
    flush = 1'b1; start = 1'b0;
    #1;
    check("done_flush_rv", {31'b0, result_valid}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("done_flush_idle", {31'b0, busy}, 32'd0);
    count_pulses("done_flush_no_pulse", 5);

    // Back-to-back divides, second with operands changing after accept
    run_op("b2b_divu_7", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    run_op("b2b_divu_9", ALU_DIVU, 32'd100, 32'd9, 32'd11, 33, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
